// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encoding and clamp minimums for the pulse train controller
package pulse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM_ON  = 3'd1,
        ST_ON      = 3'd2,
        ST_ARM_OFF = 3'd3,
        ST_OFF     = 3'd4
    } state_t;

    // toff floor of 3 covers the ARM_OFF + OFF + ARM_ON overhead cycles
    localparam int TON_MIN  = 1;
    localparam int TOFF_MIN = 3;

endpackage

// File: rtl/pulse_start_timer.sv
// rtl/pulse_start_timer.sv - free-running phase timer, loaded by start_pulse and stopped by timer_reset
module pulse_start_timer #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_pulse,
    input  logic             timer_reset,
    output logic [WIDTH-1:0] output_timer
);

    logic running;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            output_timer <= '0;
            running      <= 1'b0;
        end else if (timer_reset) begin
            output_timer <= INIT_VALUE;
            running      <= 1'b0;
        end else if (start_pulse) begin
            output_timer <= INIT_VALUE;
            running      <= 1'b1;
        end else if (running) begin
            output_timer <= output_timer + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pulse_phase_ctrl.sv
// rtl/pulse_phase_ctrl.sv - pulse train sequencer driving a gate from an external phase timer
module pulse_phase_ctrl
    import pulse_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     ton_cfg,
    input  logic [WIDTH-1:0]     toff_cfg,
    input  logic [CNT_WIDTH-1:0] pulse_num,
    input  logic [WIDTH-1:0]     timer_value,
    output logic                 start_pulse,
    output logic                 timer_reset,
    output logic                 gate_on,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pulse_cnt
);

    state_t               state;
    logic [WIDTH-1:0]     ton_lim;
    logic [WIDTH-1:0]     toff_lim;
    logic [CNT_WIDTH-1:0] num_lat;

    logic [WIDTH-1:0]     ton_clamped;
    logic [WIDTH-1:0]     toff_clamped;
    logic                 on_end;
    logic                 off_end;
    logic                 last_pulse;

    assign ton_clamped  = (ton_cfg  < WIDTH'(TON_MIN))  ? WIDTH'(TON_MIN)  : ton_cfg;
    assign toff_clamped = (toff_cfg < WIDTH'(TOFF_MIN)) ? WIDTH'(TOFF_MIN) : toff_cfg;

    // >= rather than == so a stale or overrun timer still closes the phase
    assign on_end     = (state == ST_ON)  && (timer_value >= ton_lim);
    assign off_end    = (state == ST_OFF) && (timer_value >= toff_lim);
    assign last_pulse = (num_lat != '0) && (pulse_cnt == num_lat);

    assign busy        = (state != ST_IDLE);
    assign gate_on     = (state == ST_ON);
    assign start_pulse = ((state == ST_ARM_ON) || (state == ST_ARM_OFF)) && !abort;
    assign timer_reset = busy && (abort || on_end || off_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ton_lim   <= '0;
            toff_lim  <= '0;
            num_lat   <= '0;
            pulse_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            ton_lim   <= ton_clamped - WIDTH'(TON_MIN);
                            toff_lim  <= toff_clamped - WIDTH'(TOFF_MIN);
                            num_lat   <= pulse_num;
                            pulse_cnt <= '0;
                            state     <= ST_ARM_ON;
                        end
                    end
                    ST_ARM_ON:  state <= ST_ON;
                    ST_ON: begin
                        if (on_end) begin
                            pulse_cnt <= pulse_cnt + CNT_WIDTH'(1);
                            state     <= ST_ARM_OFF;
                        end
                    end
                    ST_ARM_OFF: state <= ST_OFF;
                    ST_OFF: begin
                        if (off_end) begin
                            if (last_pulse) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_ARM_ON;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_phase_ctrl.sv
// tb/tb_pulse_phase_ctrl.sv - scoreboard bench for pulse_phase_ctrl with the phase timer attached
module tb_pulse_phase_ctrl;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 4;
    localparam int EV_RISE   = 0;
    localparam int EV_FALL   = 1;
    localparam int EV_DONE   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [WIDTH-1:0]     ton_cfg = '0;
    logic [WIDTH-1:0]     toff_cfg = '0;
    logic [CNT_WIDTH-1:0] pulse_num = '0;
    logic [WIDTH-1:0]     timer_value;
    logic                 start_pulse;
    logic                 timer_reset;
    logic                 gate_on;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] pulse_cnt;
    logic                 timer_rst_n;

    assign timer_rst_n = ~rst;

    pulse_phase_ctrl #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .ton_cfg     (ton_cfg),
        .toff_cfg    (toff_cfg),
        .pulse_num   (pulse_num),
        .timer_value (timer_value),
        .start_pulse (start_pulse),
        .timer_reset (timer_reset),
        .gate_on     (gate_on),
        .busy        (busy),
        .done        (done),
        .pulse_cnt   (pulse_cnt)
    );

    pulse_start_timer #(.WIDTH(WIDTH), .INIT_VALUE('0)) u_timer (
        .clk          (clk),
        .rst_n        (timer_rst_n),
        .start_pulse  (start_pulse),
        .timer_reset  (timer_reset),
        .output_timer (timer_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_ev(int k, int c, int n);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.cnt  = n & ((1 << CNT_WIDTH) - 1);
        exp_q.push_back(e);
    endtask

    task automatic expect_run(int t0, int ton, int toff, int n, bit with_done);
        int p = ton + toff;
        for (int k = 0; k < n; k++) begin
            expect_ev(EV_RISE, t0 + 2 + k * p, k);
            expect_ev(EV_FALL, t0 + 2 + k * p + ton, k + 1);
        end
        if (with_done) expect_ev(EV_DONE, t0 + 1 + n * p, n);
    endtask

    task automatic observe(int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", k, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
            check("event_cnt", int'(pulse_cnt), e.cnt);
        end
    endtask

    bit prev_gate = 1'b0;
    always @(negedge clk) begin
        if (gate_on && !prev_gate) observe(EV_RISE);
        if (!gate_on && prev_gate) observe(EV_FALL);
        if (done) observe(EV_DONE);
        prev_gate = gate_on;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(int n);
        while (cyc < n) tick();
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy && i < 300) begin
            tick();
            i++;
        end
        check("idle_within_budget", int'(busy), 0);
        repeat (3) tick();
    endtask

    task automatic begin_run(int ton, int toff, int n);
        ton_cfg   = WIDTH'(ton);
        toff_cfg  = WIDTH'(toff);
        pulse_num = CNT_WIDTH'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_gate_on", int'(gate_on), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_start_pulse", int'(start_pulse), 0);
        check("reset_timer_reset", int'(timer_reset), 0);
        check("reset_pulse_cnt", int'(pulse_cnt), 0);
        tick();

        // three 5/10 pulses: gate 2-6, 17-21, 32-36, done at 46
        t0 = cyc;
        expect_ev(EV_RISE, t0 + 2, 0);  expect_ev(EV_FALL, t0 + 7, 1);
        expect_ev(EV_RISE, t0 + 17, 1); expect_ev(EV_FALL, t0 + 22, 2);
        expect_ev(EV_RISE, t0 + 32, 2); expect_ev(EV_FALL, t0 + 37, 3);
        expect_ev(EV_DONE, t0 + 46, 3);
        begin_run(5, 10, 3);
        wait_idle();
        check("run1_final_cnt", int'(pulse_cnt), 3);

        // ton=0 and toff=1 clamp to 1 and 3
        t0 = cyc;
        expect_run(t0, 1, 3, 2, 1'b1);
        begin_run(0, 1, 2);
        wait_idle();

        // abort in the 4th ON cycle of the first pulse
        t0 = cyc;
        expect_ev(EV_RISE, t0 + 2, 0);
        expect_ev(EV_FALL, t0 + 6, 0);
        begin_run(8, 8, 5);
        at_cycle(t0 + 5);
        abort = 1'b1;
        @(negedge clk);
        check("abort_timer_reset", int'(timer_reset), 1);
        check("abort_gate_still_on", int'(gate_on), 1);
        at_cycle(t0 + 6);
        abort = 1'b0;
        @(negedge clk);
        check("abort_gate_off", int'(gate_on), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_timer_reset_cleared", int'(timer_reset), 0);
        check("abort_pulse_cnt", int'(pulse_cnt), 0);
        check("abort_timer_value", int'(timer_value), 0);
        repeat (5) tick();

        // abort during ARM_ON suppresses start_pulse
        begin_run(3, 3, 1);
        abort = 1'b1;
        @(negedge clk);
        check("arm_abort_start_pulse", int'(start_pulse), 0);
        check("arm_abort_timer_reset", int'(timer_reset), 1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("arm_abort_busy", int'(busy), 0);
        tick();

        // start together with abort in IDLE is ignored
        abort = 1'b1;
        begin_run(4, 4, 1);
        abort = 1'b0;
        @(negedge clk);
        check("start_with_abort_busy", int'(busy), 0);
        tick();

        // continuous mode, 20 pulses of period 5, count wraps through 15->0
        t0 = cyc;
        expect_run(t0, 2, 3, 20, 1'b0);
        begin_run(2, 3, 0);
        at_cycle(t0 + 100);
        abort = 1'b1;
        at_cycle(t0 + 101);
        abort = 1'b0;
        @(negedge clk);
        check("cont_pulse_cnt_wrapped", int'(pulse_cnt), 4);
        check("cont_busy", int'(busy), 0);
        repeat (5) tick();

        // a second start and new cfg mid-run are ignored
        t0 = cyc;
        expect_run(t0, 4, 6, 2, 1'b1);
        begin_run(4, 6, 2);
        at_cycle(t0 + 4);
        start     = 1'b1;
        ton_cfg   = WIDTH'(9);
        toff_cfg  = WIDTH'(20);
        pulse_num = CNT_WIDTH'(7);
        at_cycle(t0 + 5);
        start = 1'b0;
        @(negedge clk);
        check("restart_busy", int'(busy), 1);
        wait_idle();
        check("restart_final_cnt", int'(pulse_cnt), 2);

        // rst during the second ON phase
        t0 = cyc;
        expect_ev(EV_RISE, t0 + 2, 0);
        expect_ev(EV_FALL, t0 + 7, 1);
        expect_ev(EV_RISE, t0 + 12, 1);
        expect_ev(EV_FALL, t0 + 15, 0);
        begin_run(5, 5, 3);
        at_cycle(t0 + 14);
        rst = 1'b1;
        at_cycle(t0 + 15);
        rst = 1'b0;
        @(negedge clk);
        check("rst_gate_on", int'(gate_on), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_start_pulse", int'(start_pulse), 0);
        check("rst_timer_reset", int'(timer_reset), 0);
        check("rst_pulse_cnt", int'(pulse_cnt), 0);
        repeat (5) tick();

        wait_idle();
        check("pending_events", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
